// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared definitions for the memory-port arbiter: the arbiter state
//   encoding, the requester ids used to index grant vectors, and the default
//   geometry of the off-chip memory port.
//
//   Contents:
//     ADDR_W_DEF   default line-address width
//     LINE_W_DEF   default cache-line width
//     TIMEOUT_DEF  default number of silent wait cycles before err_timeout
//     REQ_I/REQ_D  requester ids (bit positions in req/gnt vectors)
//     arb_state_e  arbiter FSM states
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 28;
    localparam int LINE_W_DEF  = 128;
    localparam int TIMEOUT_DEF = 255;

    // Requester ids double as bit positions in the req/gnt vectors and as
    // the encoding of the last-grant register.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way round-robin picker. A lone request is granted
//   directly; when both requesters ask, the one that was not granted last
//   time wins.
//
//   Ports:
//     req   [1:0]  request vector, bit REQ_I = I-cache, bit REQ_D = D-cache
//     last         id of the requester granted most recently
//     gnt   [1:0]  one-hot grant (all zero when nothing is requested)
// ----------------------------------------------------------------------------
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
            // Tie: hand the port to whoever did not have it last.
            if (last == REQ_I) begin
                gnt[REQ_D] = 1'b1;
            end else begin
                gnt[REQ_I] = 1'b1;
            end
        end
    end

endmodule : rr_pick2

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single off-chip memory port between the I-cache refill path
//   and the D-cache refill/write-back path. Round-robin arbitration, one
//   outstanding memory transaction at a time. Command, address and write
//   data are registered toward memory; read data and the ready pulse are
//   registered back toward the winning cache.
//
//   Handshake: a cache raises i_read / d_read / d_write with a stable
//   address (and d_wdata for a write-back) and holds it until its ready
//   output pulses for one cycle; that pulse is the only completion
//   indication and the returned line is valid in i_rdata / d_rdata from the
//   pulse onward. Toward memory, mem_read / mem_write stay high with stable
//   mem_addr / mem_wdata until memory answers with a one-cycle mem_ready
//   (mem_rdata valid in that same cycle).
//
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     i_read, i_addr             I-cache line-read request
//     i_rdata, i_ready           line and completion pulse to the I-cache
//     d_read, d_write, d_addr,   D-cache refill / write-back request
//     d_wdata
//     d_rdata, d_ready           line and completion pulse to the D-cache
//     mem_read, mem_write,       registered memory command
//     mem_addr, mem_wdata
//     mem_rdata, mem_ready       memory response
//     busy                       arbiter is not in IDLE
//     err_timeout                sticky: memory went silent for TIMEOUT cycles
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_ready,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy,
    output logic              err_timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_e        state_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              i_ready_q;
    logic              d_ready_q;

    // ------------------------------------------------------------------
    // Arbitration: request vector and round-robin pick
    // ------------------------------------------------------------------
    logic [1:0] req;
    logic [1:0] gnt;

    always_comb begin
        req        = 2'b00;
        req[REQ_I] = i_read;
        req[REQ_D] = d_read | d_write;
    end

    rr_pick2 u_pick (
        .req  (req),
        .last (last_q),
        .gnt  (gnt)
    );

    // ------------------------------------------------------------------
    // Saturating wait counter next value
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= REQ_D;     // so the I-cache wins the first tie
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses; only the completion
            // edge sets them.
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (gnt[REQ_I]) begin
                        state_q     <= GNT_I;
                        last_q      <= REQ_I;
                        cnt_q       <= '0;
                        mem_addr_q  <= i_addr;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                    end else if (gnt[REQ_D]) begin
                        state_q    <= GNT_D;
                        last_q     <= REQ_D;
                        cnt_q      <= '0;
                        mem_addr_q <= d_addr;
                        // d_read and d_write together is illegal from the
                        // cache; the write-back wins so no dirty line is lost.
                        if (d_write) begin
                            mem_write_q <= 1'b1;
                            mem_read_q  <= 1'b0;
                            mem_wdata_q <= d_wdata;
                        end else begin
                            mem_write_q <= 1'b0;
                            mem_read_q  <= 1'b1;
                        end
                    end
                end

                GNT_I, GNT_D: begin
                    // Requester inputs are deliberately not looked at here:
                    // the command already issued to memory is authoritative.
                    if (mem_ready) begin
                        state_q     <= DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state_q == GNT_I) begin
                            i_rdata_q <= mem_rdata;
                            i_ready_q <= 1'b1;
                        end else begin
                            // A write-back returns no line; keep the last one.
                            if (!mem_write_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                            d_ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_MAX) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // No grant here: the served cache only drops its request
                    // after seeing the ready pulse, so arbitrating now could
                    // re-serve a stale request.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_ready     = i_ready_q;
    assign d_ready     = d_ready_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != IDLE);

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache refill path and the D-cache refill/write-back path.
- Sits between both cache controllers and the slow memory model, below the RISC-V pipeline.
- Arbitration is round-robin with one outstanding transaction at a time.
- Address, write data and command are registered toward memory; read data and ready are registered back to the winning cache.

Parameters:
- ADDR_W, 28, line-address width (word address without the 2-bit line offset).
- LINE_W, 128, cache-line width in bits.
- TIMEOUT, 255, cycles without mem_ready before err_timeout asserts; counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- i_read  in  1  I-cache line-read request; held until i_ready.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to I-cache.
- i_ready  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line-read request; held until d_ready.
- d_write  in  1  D-cache line write-back request; held until d_ready.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache write-back line.
- d_rdata  out  LINE_W  line returned to D-cache.
- d_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  LINE_W  memory write data.
- mem_rdata  in  LINE_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, one cycle.
- busy  out  1  high when state is not IDLE.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; last_grant=D, so I wins the first tie; all outputs 0; timeout counter 0.
- States: IDLE, GNT_I, GNT_D, DONE.
- IDLE:
  - d_req = d_read | d_write.
  - If only one of i_read / d_req is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - On the grant edge, register mem_addr / mem_wdata / mem_read / mem_write from the winner and update last_grant.
  - For a D write-back, mem_wdata = d_wdata. For a read, mem_wdata holds its previous value.
  - d_read and d_write both high is illegal; write wins, with mem_write=1 and mem_read=0.
- GNT_I / GNT_D:
  - mem_* stay stable.
  - Requester inputs are ignored, so a dropped or changed request has no effect.
  - On a cycle with mem_ready=1:
    - clear mem_read and mem_write;
    - register mem_rdata into i_rdata or d_rdata (d_rdata is loaded for reads only; it holds its value on a write);
    - pulse the matching ready for exactly the next cycle;
    - go to DONE.
- DONE:
  - One cycle; the ready pulse is visible here.
  - No grant is made, which guarantees the served cache has dropped its request.
  - Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle t gives mem_read/mem_write high from t+1.
  - mem_ready at cycle m gives the ready pulse at m+1.
  - The next grant is possible no earlier than m+2, registered at the m+2 edge.
- i_rdata and d_rdata hold their values until the next completion for that requester.
- Timeout:
  - The counter increments each GNT_* cycle without mem_ready and saturates.
  - When it reaches TIMEOUT, err_timeout is set and stays set until rst.
  - The transaction keeps waiting.
  - The counter clears on entry to GNT_*.
- mem_ready in IDLE or DONE is ignored.
- rst asserted mid-transaction: immediate return to reset values, with no ready pulse. Memory is expected to be reset with the arbiter.
- busy = (state != IDLE), decoded from the registered state.

Decomposition:
- Shared package, e.g. mem_arb_pkg:
  - state enum {IDLE, GNT_I, GNT_D, DONE};
  - requester id localparams REQ_I=0, REQ_D=1;
  - default ADDR_W and LINE_W.
- One natural sub-module: rr_pick2, the combinational two-way round-robin picker with inputs req[1:0] and last, and one-hot output gnt.
- The FSM, timeout counter and registers stay in mem_arbiter.

Test Plan:
- Lone I read: i_read=1, i_addr=0x0000123 at t0; memory returns 0xAA..AA with mem_ready at t0+5.
  - Required: mem_read=1 and mem_addr=0x0000123 from t0+1.
  - Required: i_ready pulses at t0+6 with i_rdata=0xAA..AA; d_ready stays 0.
- Simultaneous I and D after reset: both request at t0.
  - Required: I granted first.
  - Required: D granted at the first IDLE after DONE, with mem_addr=d_addr.
  - Required: a third simultaneous pair grants I again.
- D write-back: d_write=1, d_addr=0x10, d_wdata=0x55..55.
  - Required: mem_write=1 with matching addr/data.
  - Required: d_ready pulses once and d_rdata is unchanged.
- Illegal d_read and d_write both high: required mem_write=1, mem_read=0.
- Request held through DONE: cache keeps i_read high one cycle past i_ready.
  - Required: no second grant in DONE; a new grant occurs in the following IDLE cycle.
- Timeout and reset: withhold mem_ready for 255 cycles.
  - Required: err_timeout rises at the 255th wait cycle and stays high after mem_ready arrives.
  - Then assert rst mid-transaction: all outputs 0 next cycle and state IDLE.
